case_arbiter: RTL and testbench
===============================

CASE_ARBITER -- requirements
Module: case_arbiter

Interface
REQ-001 Parameter: size, default 1, width of each requester's data word and of out_data.
REQ-002 Parameter: max_hold, default 8, maximum BUSY cycles per grant; legal range 1..255.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  3  request per requester; index 2, 1, 0.
REQ-006 Port: last  input  3  per-requester end-of-transfer marker; honoured only for the granted requester.
REQ-007 Port: src2, src1, src0  input  size each  requester data words.
REQ-008 Port: mode  input  1  arbitration policy: 0 = fixed priority, 1 = round-robin.
REQ-009 Port: gnt  output  3  one-hot grant, or all zero.
REQ-010 Port: gnt_code  output  2  encoded grant: 0 = req2, 1 = req1, 2 = req0, 3 = none.
REQ-011 Port: out_data  output  size  data of the granted requester.
REQ-012 Port: out_valid  output  1  granted requester is transferring this cycle.
REQ-013 Port: busy  output  1  FSM is in BUSY.
REQ-014 Port: preempt  output  1  one-cycle pulse when a grant is forcibly released.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and BUSY, and SHALL reset to IDLE.
REQ-016 In IDLE with req != 0, the block SHALL select a winner, assert its gnt bit from the next cycle, and enter BUSY; with req == 0 it SHALL stay in IDLE.
REQ-017 Fixed priority (mode=0) SHALL use order 2 > 1 > 0, the same as matching patterns 1??, 01?, 001.
REQ-018 Round-robin (mode=1) SHALL search starting after the last-granted index, descending with wrap: after 2 -> 1,0,2; after 1 -> 0,2,1; after 0 -> 2,1,0.
REQ-019 The last-granted pointer SHALL reset to 0, so the first round-robin search order equals the fixed order.
REQ-020 mode SHALL be sampled only on the IDLE->BUSY decision; changes during BUSY SHALL have no effect until the next arbitration.
REQ-021 gnt and gnt_code SHALL be registered and SHALL stay constant for the whole BUSY period.
REQ-022 In BUSY, out_valid SHALL equal req[g], where g is the granted index.
REQ-023 In BUSY, out_data SHALL equal src_g combinationally; whenever out_valid is 0, out_data SHALL be 0.
REQ-024 A hold counter (8 bits) SHALL load 1 on the grant cycle and increment each further BUSY cycle.
REQ-025 BUSY SHALL exit to IDLE on the first of the following, evaluated in this priority:
  - (a) req[g] & last[g] — normal completion;
  - (b) req[g] == 0 — abort;
  - (c) counter == max_hold — preemption.
REQ-026 preempt SHALL pulse high for exactly the cycle after a (c) exit, and never after (a) or (b).
REQ-027 When (a) and (c) occur in the same cycle, the exit SHALL count as (a), with no preempt.
REQ-028 After any BUSY exit, gnt SHALL be 0 and gnt_code 3 for at least one IDLE cycle before the next grant.
REQ-029 The last-granted pointer SHALL update on every grant, in both modes.
REQ-030 last bits of non-granted requesters SHALL be ignored.
REQ-031 With max_hold=1, every grant SHALL last exactly one BUSY cycle.

Reset
REQ-032 While rst_n=0, regardless of clk, the outputs SHALL be:
  - gnt=000, gnt_code=3, out_data=0, out_valid=0, busy=0, preempt=0;
  - FSM=IDLE, pointer=0, counter=0.
REQ-033 Reset asserted mid-BUSY SHALL drop the grant immediately (asynchronously), with no preempt pulse.
REQ-034 After rst_n deasserts, the first arbitration SHALL occur on the first rising edge that sees req != 0.

Verification
REQ-035 mode=0, req=111 held, last=111 each BUSY cycle, size=4, src2=4'hA -> grant cycles give gnt=100, gnt_code=0, out_data=4'hA; every grant goes to requester 2, with one idle cycle between grants.
REQ-036 mode=1, req=111 held, last=111 -> successive gnt_code values 0,1,2,0,1,2, separated by single gnt_code=3 idle cycles.
REQ-037 max_hold=8, req=010 held, last=000 -> gnt=010 for exactly 8 cycles, then preempt=1 for one cycle with gnt=000, then re-grant to requester 1.
REQ-038 Requester 0 granted, req drops to 000 on the 3rd BUSY cycle -> out_valid=0 and out_data=0 that cycle, then IDLE, with no preempt.
REQ-039 max_hold=4, last[g]=1 on the 4th BUSY cycle -> normal completion with preempt=0; mode toggled mid-BUSY -> grant unchanged.
REQ-040 rst_n pulsed low mid-BUSY between edges -> gnt=000 and busy=0 immediately; after release, req=001 in mode=1 -> gnt=001, gnt_code=2.

Source files
------------

// File: rtl/case_arbiter_if.sv
// Purpose: bundles the three-requester request/data lines and the grant/result lines of case_arbiter.
// Latency: none, wires only.
// Backpressure: none; req/last act as per-requester valid/end-of-transfer, gnt as the ready side.
interface case_arbiter_if #(
   parameter int size = 1
);
   logic [2:0]      req;
   logic [2:0]      last;
   logic [size-1:0] src2;
   logic [size-1:0] src1;
   logic [size-1:0] src0;
   logic            mode;
   logic [2:0]      gnt;
   logic [1:0]      gnt_code;
   logic [size-1:0] out_data;
   logic            out_valid;
   logic            busy;
   logic            preempt;

   // Requester side: drives requests and data, observes the grant.
   modport master (
      output req, last, src2, src1, src0, mode,
      input  gnt, gnt_code, out_data, out_valid, busy, preempt
   );

   // Arbiter side.
   modport slave (
      input  req, last, src2, src1, src0, mode,
      output gnt, gnt_code, out_data, out_valid, busy, preempt
   );
endinterface

// File: rtl/case_arbiter.sv
// Purpose: 3-way arbiter (fixed or round-robin) holding one grant until last, abort or max_hold preemption.
// Latency: grant registered one cycle after req seen in IDLE; out_data/out_valid combinational while BUSY.
// Backpressure: a requester keeps the bus while req[g] stays high, capped at max_hold cycles.
module case_arbiter #(
   parameter int size     = 1,
   parameter int max_hold = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   case_arbiter_if.slave  bus
);
   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] BUSY     = 1'b1;
   localparam logic [7:0] HOLD_LIM = 8'(max_hold);

   logic [0:0]      state_q, state_d;
   logic [2:0]      gnt_q, gnt_d;
   logic [1:0]      code_q, code_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            preempt_q, preempt_d;

   logic [1:0]      start;
   logic [1:0]      win;
   logic            req_g;
   logic            last_g;
   logic            at_limit;
   logic [size-1:0] src_g;

   // Winner search: descending from just below the start index, wrapping; start 0 gives 2,1,0.
   always_comb begin
      start = bus.mode ? ptr_q : 2'd0;
      win   = 2'd0;
      case (start)
         2'd1: begin
            if (bus.req[0])      win = 2'd0;
            else if (bus.req[2]) win = 2'd2;
            else                 win = 2'd1;
         end
         2'd2: begin
            if (bus.req[1])      win = 2'd1;
            else if (bus.req[0]) win = 2'd0;
            else                 win = 2'd2;
         end
         default: begin
            if (bus.req[2])      win = 2'd2;
            else if (bus.req[1]) win = 2'd1;
            else                 win = 2'd0;
         end
      endcase
   end

   // Signals of the currently granted requester; last of the others is masked off by the one-hot grant.
   always_comb begin
      req_g    = |(bus.req & gnt_q);
      last_g   = |(bus.req & bus.last & gnt_q);
      at_limit = (cnt_q == HOLD_LIM);
      src_g    = ({size{gnt_q[2]}} & bus.src2)
               | ({size{gnt_q[1]}} & bus.src1)
               | ({size{gnt_q[0]}} & bus.src0);
   end

   // Next-state logic: arbitrate in IDLE, hold/exit in BUSY with completion > abort > preemption.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      code_d    = code_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      preempt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               state_d = BUSY;
               gnt_d   = 3'b001 << win;
               code_d  = 2'd2 - win;
               ptr_d   = win;
               cnt_d   = 8'd1;
            end
         end
         default: begin
            if (last_g || !req_g || at_limit) begin
               state_d   = IDLE;
               gnt_d     = 3'b000;
               code_d    = 2'd3;
               cnt_d     = 8'd0;
               preempt_d = at_limit && req_g && !last_g;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
   end

   // State registers; reset drops any grant at once without a preempt pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 3'b000;
         code_q    <= 2'd3;
         ptr_q     <= 2'd0;
         cnt_q     <= 8'd0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         code_q    <= code_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         preempt_q <= preempt_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_code  = code_q;
   assign bus.busy      = (state_q == BUSY);
   assign bus.out_valid = (state_q == BUSY) && req_g;
   assign bus.out_data  = bus.out_valid ? src_g : '0;
   assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_case_arbiter.sv
// Purpose: self-checking bench for case_arbiter at max_hold 8, 4 and 1 driven with shared stimulus.
// Latency: inputs change just after the falling edge, outputs sampled 1 ns later.
// Backpressure: n/a (bench).
module tb_case_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] req, last;
   logic       mode;
   logic [3:0] src2, src1, src0;

   always #5 clk = ~clk;

   case_arbiter_if #(.size(4)) if8 ();
   case_arbiter_if #(.size(4)) if4 ();
   case_arbiter_if #(.size(4)) if1 ();

   assign if8.req = req;   assign if8.last = last;  assign if8.mode = mode;
   assign if8.src2 = src2; assign if8.src1 = src1;  assign if8.src0 = src0;
   assign if4.req = req;   assign if4.last = last;  assign if4.mode = mode;
   assign if4.src2 = src2; assign if4.src1 = src1;  assign if4.src0 = src0;
   assign if1.req = req;   assign if1.last = last;  assign if1.mode = mode;
   assign if1.src2 = src2; assign if1.src1 = src1;  assign if1.src0 = src0;

   case_arbiter #(.size(4), .max_hold(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
   case_arbiter #(.size(4), .max_hold(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
   case_arbiter #(.size(4), .max_hold(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       rst_n;
      logic       mode;
      logic [2:0] req;
      logic [2:0] last;
      logic [2:0] gnt;
      logic [1:0] code;
      logic [3:0] data;
      logic       valid;
      logic       busy;
      logic       pre;
   } vec_t;
   vec_t tbl[$];

   // Reference model: one record per instance, expressed as granted index + hold count.
   logic m_busy[3];
   logic m_pre[3];
   int   m_g[3];
   int   m_ptr[3];
   int   m_cnt[3];
   int   hold[3];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(logic r, logic m, logic [2:0] rq, logic [2:0] ls);
      @(negedge clk);
      rst_n = r; mode = m; req = rq; last = ls;
      #1;
   endtask

   task automatic add(logic r, logic m, logic [2:0] rq, logic [2:0] ls,
                      logic [2:0] g, logic [1:0] cd, logic [3:0] d, logic v, logic b, logic p);
      vec_t e;
      e.rst_n = r; e.mode = m; e.req = rq; e.last = ls;
      e.gnt = g; e.code = cd; e.data = d; e.valid = v; e.busy = b; e.pre = p;
      tbl.push_back(e);
   endtask

   function automatic logic [11:0] outs(int k);
      case (k)
         0:       return {if8.gnt, if8.gnt_code, if8.out_data, if8.out_valid, if8.busy, if8.preempt};
         1:       return {if4.gnt, if4.gnt_code, if4.out_data, if4.out_valid, if4.busy, if4.preempt};
         default: return {if1.gnt, if1.gnt_code, if1.out_data, if1.out_valid, if1.busy, if1.preempt};
      endcase
   endfunction

   function automatic logic [3:0] src_of(int g);
      if (g == 2) return src2;
      if (g == 1) return src1;
      return src0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_busy[k] = 1'b0; m_pre[k] = 1'b0; m_g[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      end
   endtask

   function automatic logic [11:0] model_out(int k);
      logic [2:0] g3;
      logic [1:0] cd;
      logic [3:0] d;
      logic       v;
      g3 = 3'b000; cd = 2'd3; d = 4'h0; v = 1'b0;
      if (m_busy[k]) begin
         g3 = 3'b001 << m_g[k];
         cd = 2'(2 - m_g[k]);
         v  = req[m_g[k]];
         d  = v ? src_of(m_g[k]) : 4'h0;
      end
      return {g3, cd, d, v, m_busy[k], m_pre[k]};
   endfunction

   // Advance one instance across a rising edge using the inputs now applied.
   task automatic model_step(int k);
      int  start, c, pick;
      bit  found;
      if (!m_busy[k]) begin
         m_pre[k] = 1'b0;
         if (req != 3'b000) begin
            start = mode ? m_ptr[k] : 0;
            found = 1'b0;
            pick  = 0;
            for (int s = 1; s <= 3; s++) begin
               c = (start - s + 3) % 3;
               if (!found && req[c]) begin
                  found = 1'b1;
                  pick  = c;
               end
            end
            m_busy[k] = 1'b1; m_g[k] = pick; m_ptr[k] = pick; m_cnt[k] = 1;
         end
      end else if (req[m_g[k]] && last[m_g[k]]) begin
         m_busy[k] = 1'b0; m_pre[k] = 1'b0;
      end else if (!req[m_g[k]]) begin
         m_busy[k] = 1'b0; m_pre[k] = 1'b0;
      end else if (m_cnt[k] == hold[k]) begin
         m_busy[k] = 1'b0; m_pre[k] = 1'b1;
      end else begin
         m_cnt[k] = m_cnt[k] + 1; m_pre[k] = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; req = 3'b000; last = 3'b000;
      src2 = 4'hA; src1 = 4'h5; src0 = 4'h3;
      hold[0] = 8; hold[1] = 4; hold[2] = 1;

      // Fixed priority, round-robin rotation, abort, non-granted last ignored (max_hold 8 instance).
      //   rst  mode  req     last      gnt     code  data  v  b  p
      add(0, 0, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 0, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 0, 3'b111, 3'b111, 3'b100, 2'd0, 4'hA, 1, 1, 0);
      add(1, 0, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 0, 3'b111, 3'b111, 3'b100, 2'd0, 4'hA, 1, 1, 0);
      add(1, 0, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(0, 1, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b111, 3'b111, 3'b100, 2'd0, 4'hA, 1, 1, 0);
      add(1, 1, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b111, 3'b111, 3'b010, 2'd1, 4'h5, 1, 1, 0);
      add(1, 1, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b111, 3'b111, 3'b001, 2'd2, 4'h3, 1, 1, 0);
      add(1, 1, 3'b111, 3'b111, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b111, 3'b111, 3'b100, 2'd0, 4'hA, 1, 1, 0);
      add(1, 1, 3'b000, 3'b000, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b001, 3'b000, 3'b000, 2'd3, 4'h0, 0, 0, 0);
      add(1, 1, 3'b001, 3'b000, 3'b001, 2'd2, 4'h3, 1, 1, 0);
      add(1, 1, 3'b101, 3'b100, 3'b001, 2'd2, 4'h3, 1, 1, 0);
      add(1, 1, 3'b100, 3'b000, 3'b001, 2'd2, 4'h0, 0, 1, 0);
      add(1, 1, 3'b000, 3'b000, 3'b000, 2'd3, 4'h0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst_n, tbl[i].mode, tbl[i].req, tbl[i].last);
         check($sformatf("tbl[%0d]", i), 32'(outs(0)),
               32'({tbl[i].gnt, tbl[i].code, tbl[i].data, tbl[i].valid, tbl[i].busy, tbl[i].pre}));
      end

      // Preemption at max_hold 8, and single-cycle grants at max_hold 1.
      step(0, 0, 3'b010, 3'b000);
      step(1, 0, 3'b010, 3'b000);
      check("hold8_idle_gnt", 32'(if8.gnt), 32'(3'b000));
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 3'b010, 3'b000);
         check($sformatf("hold8_gnt[%0d]", i), 32'({if8.gnt, if8.preempt}), 32'({3'b010, 1'b0}));
         check($sformatf("hold1_cyc[%0d]", i), 32'({if1.gnt, if1.preempt}),
               (i % 2 == 1) ? 32'({3'b010, 1'b0}) : 32'({3'b000, 1'b1}));
      end
      step(1, 0, 3'b010, 3'b000);
      check("hold8_preempt", 32'({if8.gnt, if8.gnt_code, if8.preempt}), 32'({3'b000, 2'd3, 1'b1}));
      step(1, 0, 3'b010, 3'b000);
      check("hold8_regrant", 32'({if8.gnt, if8.preempt}), 32'({3'b010, 1'b0}));

      // max_hold 4: last on the 4th cycle is a normal completion; mode flip mid-grant is ignored.
      step(0, 1, 3'b011, 3'b000);
      step(1, 1, 3'b011, 3'b000);
      step(1, 1, 3'b011, 3'b000);
      check("hold4_first_gnt", 32'({if4.gnt, if4.gnt_code}), 32'({3'b010, 2'd1}));
      step(1, 0, 3'b011, 3'b000);
      check("hold4_mode_flip", 32'({if4.gnt, if4.gnt_code}), 32'({3'b010, 2'd1}));
      step(1, 0, 3'b011, 3'b001);
      check("hold4_other_last", 32'({if4.gnt, if4.busy}), 32'({3'b010, 1'b1}));
      step(1, 0, 3'b011, 3'b010);
      check("hold4_last_cycle", 32'({if4.gnt, if4.out_valid, if4.out_data}), 32'({3'b010, 1'b1, 4'h5}));
      step(1, 0, 3'b000, 3'b000);
      check("hold4_no_preempt", 32'({if4.gnt, if4.busy, if4.preempt}), 32'({3'b000, 1'b0, 1'b0}));

      // Asynchronous reset in the middle of a grant, then first arbitration after release.
      step(0, 0, 3'b100, 3'b000);
      step(1, 0, 3'b100, 3'b000);
      step(1, 0, 3'b100, 3'b000);
      check("arst_pre_busy", 32'({if8.gnt, if8.busy}), 32'({3'b100, 1'b1}));
      #2 rst_n = 1'b0;
      #1;
      check("arst_async_drop", 32'(outs(0)), 32'({3'b000, 2'd3, 4'h0, 1'b0, 1'b0, 1'b0}));
      step(0, 1, 3'b001, 3'b000);
      step(1, 1, 3'b001, 3'b000);
      check("arst_release_idle", 32'({if8.gnt, if8.gnt_code}), 32'({3'b000, 2'd3}));
      step(1, 1, 3'b001, 3'b000);
      check("arst_first_grant", 32'({if8.gnt, if8.gnt_code}), 32'({3'b001, 2'd2}));

      // Randomised stimulus against the reference model on all three instances.
      step(0, 0, 3'b000, 3'b000);
      model_reset();
      begin
         logic [2:0] rq;
         logic [2:0] ls;
         logic       r;
         rq = 3'b000;
         for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 3'($urandom_range(0, 7));
            ls[0] = ($urandom_range(0, 7) == 0);
            ls[1] = ($urandom_range(0, 7) == 0);
            ls[2] = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            src2 = 4'($urandom); src1 = 4'($urandom); src0 = 4'($urandom);
            rst_n = r; mode = 1'($urandom); req = rq; last = ls;
            #1;
            if (!rst_n) model_reset();
            for (int k = 0; k < 3; k++)
               check($sformatf("rand[%0d].inst%0d", n, k), 32'(outs(k)), 32'(model_out(k)));
            if (rst_n)
               for (int k = 0; k < 3; k++) model_step(k);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
